// File: rtl/rv_core_pkg.sv
// Shared core definitions used by the fetch front end.
package rv_core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so the result is a legal instruction address.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_pop;
  logic          do_push;

  // A pop on an empty buffer is meaningless; a push into a full buffer only
  // lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[head];

  // Storage, pointers and occupancy; flush drops everything but leaves data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + AW'(1);
      end
      if (do_pop) begin
        head <= head + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues word fetches, buffers results for
// decode and restarts cleanly on branch/jump redirects.
module instruction_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * INSTR_BYTES);

  logic [31:0]   pc;
  logic          in_range;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  assign imem_addr = pc;
  assign in_range  = (pc < PC_LIMIT);

  // A redirect voids any handshake in its cycle, so neither pop nor push fire.
  assign pop  = out_ready && !fifo_empty && !redirect_valid;
  assign push = !redirect_valid && !fetch_fault && in_range && (!fifo_full || pop);

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = imem_rdata;

  assign out_valid = (fifo_count != '0);
  assign out_instr = head_entry.instr;
  assign out_pc    = head_entry.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // PC sequencing and the sticky out-of-range fault; redirect outranks both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= align_pc(redirect_pc);
      fetch_fault <= 1'b0;
    end else if (push) begin
      pc <= pc + 32'(INSTR_BYTES);
    end else if (!in_range) begin
      fetch_fault <= 1'b1;
    end
  end

endmodule
